// File: rtl/cci_mpf_wr_seq_pkg.sv
// +-------------------------------------------------------------------------+
// | cci_mpf_wr_seq_pkg - shared types for the multi-beat write sequencer    |
// | Rev 1.0 - initial release                                               |
// +-------------------------------------------------------------------------+
`default_nettype none

package cci_mpf_wr_seq_pkg;

  localparam int DEF_HEAP_ENTRIES = 64;
  localparam int DEF_MAX_BEATS    = 4;
  localparam int DEF_ADDR_WIDTH   = 42;
  localparam int DEF_HDR_WIDTH    = 64;

  // Index width that stays legal when a dimension collapses to one entry.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic [$clog2(DEF_HEAP_ENTRIES)-1:0] t_heap_idx;
  typedef logic [$clog2(DEF_MAX_BEATS)-1:0]    t_beat;

  typedef enum logic [0:0] {
    SEQ_IDLE = 1'b0,
    SEQ_BEAT = 1'b1
  } t_seq_state;

  // Default-configuration view of one outgoing flit (single channel).
  typedef struct packed {
    logic [0:0]                chan;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic                      sop;
    logic                      eop;
    logic [DEF_HDR_WIDTH-1:0]  hdr;
  } t_flit;

endpackage

`default_nettype wire

// File: rtl/cci_mpf_prim_ram_dp.sv
// +-------------------------------------------------------------------------+
// | cci_mpf_prim_ram_dp - 1W/1R RAM, pipelined read, old data on collision  |
// | Rev 1.0 - initial release                                               |
// +-------------------------------------------------------------------------+
`default_nettype none

module cci_mpf_prim_ram_dp #(
  parameter int DEPTH   = 256,
  parameter int WIDTH   = 512,
  parameter int LATENCY = 2,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wen,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem     [DEPTH];
  logic [WIDTH-1:0] rd_pipe [LATENCY];

  always_ff @(posedge clk) begin
    if (wen) mem[waddr] <= wdata;
    rd_pipe[0] <= mem[raddr];
    for (int i = 1; i < LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  assign rdata = rd_pipe[LATENCY-1];

endmodule

`default_nettype wire

// File: rtl/cci_mpf_prim_rr_arb.sv
// +-------------------------------------------------------------------------+
// | cci_mpf_prim_rr_arb - round-robin grant, registered priority pointer    |
// | Rev 1.0 - initial release                                               |
// +-------------------------------------------------------------------------+
`default_nettype none

module cci_mpf_prim_rr_arb #(
  parameter int N_CHANNELS = 1,
  localparam int CW        = $clog2(N_CHANNELS) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CHANNELS-1:0] req,
  input  logic                  ack,
  output logic [N_CHANNELS-1:0] grant,
  output logic [CW-1:0]         grant_idx,
  output logic                  any
);

  // ptr names the highest-priority channel; it moves past each accepted grant.
  logic [CW-1:0] ptr;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int i = 0; i < N_CHANNELS; i++) begin
      for (int c = 0; c < N_CHANNELS; c++) begin
        if (!any && req[c] && (c == (int'(ptr) + i) % N_CHANNELS)) begin
          any       = 1'b1;
          grant[c]  = 1'b1;
          grant_idx = CW'(c);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ptr <= '0;
    else if (ack) ptr <= CW'((int'(grant_idx) + 1) % N_CHANNELS);
  end

endmodule

`default_nettype wire

// File: rtl/cci_mpf_shim_wr_beat_seq.sv
// +-------------------------------------------------------------------------+
// | cci_mpf_shim_wr_beat_seq - write-data heap + multi-beat write sequencer |
// | Rev 1.0 - optional counters under CCI_MPF_WR_SEQ_STATS_EN               |
// +-------------------------------------------------------------------------+
`default_nettype none

module cci_mpf_shim_wr_beat_seq
  import cci_mpf_wr_seq_pkg::*;
#(
  parameter int N_CHANNELS     = 1,
  parameter int N_HEAP_ENTRIES = 64,
  parameter int MAX_BEATS      = 4,
  parameter int DATA_WIDTH     = 512,
  parameter int ADDR_WIDTH     = 42,
  parameter int HDR_WIDTH      = 64,
  parameter int RAM_LATENCY    = 2,
  localparam int IW            = clog2_min1(N_HEAP_ENTRIES),
  localparam int BW            = clog2_min1(MAX_BEATS),
  localparam int CW            = $clog2(N_CHANNELS) + 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             heap_wen,
  input  logic [IW-1:0]                    heap_widx,
  input  logic [BW-1:0]                    heap_wclnum,
  input  logic [DATA_WIDTH-1:0]            heap_wdata,
  input  logic [N_CHANNELS-1:0]            req_valid,
  output logic [N_CHANNELS-1:0]            req_ready,
  input  logic [N_CHANNELS*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_CHANNELS*BW-1:0]         req_len,
  input  logic [N_CHANNELS*IW-1:0]         req_idx,
  input  logic [N_CHANNELS*HDR_WIDTH-1:0]  req_hdr,
  input  logic                             fiu_alm_full,
  output logic                             out_valid,
  output logic [CW-1:0]                    out_chan,
  output logic [ADDR_WIDTH-1:0]            out_addr,
  output logic                             out_sop,
  output logic                             out_eop,
  output logic [HDR_WIDTH-1:0]             out_hdr,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             free_en,
  output logic [IW-1:0]                    free_idx
`ifdef CCI_MPF_WR_SEQ_STATS_EN
  ,
  output logic [31:0]                      stat_pkts,
  output logic [31:0]                      stat_beats,
  output logic [31:0]                      stat_stalls
`endif
);

  localparam int PIPE_DEPTH = RAM_LATENCY + 1;

  typedef struct packed {
    logic [CW-1:0]         chan;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  sop;
    logic                  eop;
    logic [HDR_WIDTH-1:0]  hdr;
  } flit_t;

  t_seq_state            state, state_n;
  logic [BW-1:0]         beat, beat_n, rem, rem_n;
  logic [IW-1:0]         cur_idx;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [HDR_WIDTH-1:0]  cur_hdr;
  logic [CW-1:0]         cur_chan;
  logic                  take, load, launch, last;

  logic [N_CHANNELS-1:0] arb_grant;
  logic [CW-1:0]         arb_idx;
  logic                  arb_any;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [BW-1:0]         sel_len;
  logic [IW-1:0]         sel_idx;
  logic [HDR_WIDTH-1:0]  sel_hdr;

  logic [DATA_WIDTH-1:0] ram_rdata;
  flit_t                 launch_flit;
  flit_t                 pipe_flit [PIPE_DEPTH];
  logic [PIPE_DEPTH-1:0] pipe_valid;

  cci_mpf_prim_rr_arb #(.N_CHANNELS(N_CHANNELS)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req_valid),
    .ack       (load),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    sel_idx  = '0;
    sel_hdr  = '0;
    for (int c = 0; c < N_CHANNELS; c++) begin
      if (arb_idx == CW'(c)) begin
        sel_addr = req_addr[c*ADDR_WIDTH +: ADDR_WIDTH];
        sel_len  = req_len[c*BW +: BW];
        sel_idx  = req_idx[c*IW +: IW];
        sel_hdr  = req_hdr[c*HDR_WIDTH +: HDR_WIDTH];
      end
    end
  end

  // A new packet is accepted either from IDLE or on the last beat of the
  // current one, which keeps back-to-back packets free of bubbles.
  always_comb begin
    state_n   = state;
    beat_n    = beat;
    rem_n     = rem;
    take      = 1'b0;
    launch    = 1'b0;
    load      = 1'b0;
    req_ready = '0;
    case (state)
      SEQ_IDLE: take = 1'b1;
      SEQ_BEAT: begin
        if (!fiu_alm_full) begin
          launch = 1'b1;
          if (rem == '0) begin
            take    = 1'b1;
            state_n = SEQ_IDLE;
          end else begin
            beat_n = beat + 1'b1;
            rem_n  = rem - 1'b1;
          end
        end
      end
      default: state_n = SEQ_IDLE;
    endcase
    if (take && arb_any && !reset) begin
      load      = 1'b1;
      req_ready = arb_grant;
      state_n   = SEQ_BEAT;
      beat_n    = '0;
      rem_n     = sel_len;
    end
  end

  assign last = launch && (rem == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= SEQ_IDLE;
      beat    <= '0;
      rem     <= '0;
      free_en <= 1'b0;
    end else begin
      state   <= state_n;
      beat    <= beat_n;
      rem     <= rem_n;
      free_en <= last;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      cur_idx  <= sel_idx;
      cur_addr <= sel_addr;
      cur_hdr  <= sel_hdr;
      cur_chan <= arb_idx;
    end
    if (last) free_idx <= cur_idx;
  end

  cci_mpf_prim_ram_dp #(
    .DEPTH   (2 ** (IW + BW)),
    .WIDTH   (DATA_WIDTH),
    .LATENCY (RAM_LATENCY)
  ) u_heap (
    .clk   (clk),
    .wen   (heap_wen),
    .waddr ({heap_widx, heap_wclnum}),
    .wdata (heap_wdata),
    .raddr ({cur_idx, beat}),
    .rdata (ram_rdata)
  );

  always_comb begin
    launch_flit.chan = cur_chan;
    launch_flit.addr = cur_addr | ADDR_WIDTH'(beat);
    launch_flit.sop  = (beat == '0);
    launch_flit.eop  = (rem == '0);
    launch_flit.hdr  = cur_hdr;
  end

  // Header side tracks the RAM read latency plus the output data register.
  always_ff @(posedge clk) begin
    if (reset) pipe_valid <= '0;
    else pipe_valid <= {pipe_valid[PIPE_DEPTH-2:0], launch};
  end

  always_ff @(posedge clk) begin
    pipe_flit[0] <= launch_flit;
    for (int i = 1; i < PIPE_DEPTH; i++) pipe_flit[i] <= pipe_flit[i-1];
    out_data <= ram_rdata;
  end

  assign out_valid = pipe_valid[PIPE_DEPTH-1];
  assign out_chan  = pipe_flit[PIPE_DEPTH-1].chan;
  assign out_addr  = pipe_flit[PIPE_DEPTH-1].addr;
  assign out_sop   = pipe_flit[PIPE_DEPTH-1].sop;
  assign out_eop   = pipe_flit[PIPE_DEPTH-1].eop;
  assign out_hdr   = pipe_flit[PIPE_DEPTH-1].hdr;

`ifdef CCI_MPF_WR_SEQ_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_pkts   <= '0;
      stat_beats  <= '0;
      stat_stalls <= '0;
    end else begin
      if (last && stat_pkts != '1) stat_pkts <= stat_pkts + 32'd1;
      if (launch && stat_beats != '1) stat_beats <= stat_beats + 32'd1;
      if (state == SEQ_BEAT && fiu_alm_full && stat_stalls != '1)
        stat_stalls <= stat_stalls + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_cci_mpf_shim_wr_beat_seq.sv
// +-------------------------------------------------------------------------+
// | tb_cci_mpf_shim_wr_beat_seq - directed bench, 2 channels, RAM latency 2 |
// | Rev 1.0 - initial release                                               |
// +-------------------------------------------------------------------------+
`default_nettype none

module tb_cci_mpf_shim_wr_beat_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        heap_wen = 1'b0;
  logic [3:0]  heap_widx = '0;
  logic [1:0]  heap_wclnum = '0;
  logic [31:0] heap_wdata = '0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [31:0] req_addr = '0;
  logic [3:0]  req_len = '0;
  logic [7:0]  req_idx = '0;
  logic [31:0] req_hdr = '0;
  logic        fiu_alm_full = 1'b0;
  logic        out_valid;
  logic [1:0]  out_chan;
  logic [15:0] out_addr;
  logic        out_sop, out_eop;
  logic [15:0] out_hdr;
  logic [31:0] out_data;
  logic        free_en;
  logic [3:0]  free_idx;
`ifdef CCI_MPF_WR_SEQ_STATS_EN
  logic [31:0] stat_pkts, stat_beats, stat_stalls;
`endif

  cci_mpf_shim_wr_beat_seq #(
    .N_CHANNELS(2), .N_HEAP_ENTRIES(16), .MAX_BEATS(4), .DATA_WIDTH(32),
    .ADDR_WIDTH(16), .HDR_WIDTH(16), .RAM_LATENCY(2)
  ) dut (
    .clk(clk), .reset(reset),
    .heap_wen(heap_wen), .heap_widx(heap_widx), .heap_wclnum(heap_wclnum), .heap_wdata(heap_wdata),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .req_idx(req_idx), .req_hdr(req_hdr), .fiu_alm_full(fiu_alm_full),
    .out_valid(out_valid), .out_chan(out_chan), .out_addr(out_addr), .out_sop(out_sop),
    .out_eop(out_eop), .out_hdr(out_hdr), .out_data(out_data),
    .free_en(free_en), .free_idx(free_idx)
`ifdef CCI_MPF_WR_SEQ_STATS_EN
    , .stat_pkts(stat_pkts), .stat_beats(stat_beats), .stat_stalls(stat_stalls)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [1:0]  chan;
    logic [15:0] addr;
    logic        sop;
    logic        eop;
    logic [15:0] hdr;
    logic [31:0] data;
  } flit_rec_t;
  typedef struct { int cyc; logic [3:0] idx; } free_rec_t;
  typedef struct { int cyc; logic [1:0] rdy; } gnt_rec_t;

  flit_rec_t fq[$];
  free_rec_t frq[$];
  gnt_rec_t  gq[$];

  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid) fq.push_back('{cyc, out_chan, out_addr, out_sop, out_eop, out_hdr, out_data});
      if (free_en) frq.push_back('{cyc, free_idx});
      if (req_ready != 2'b00) gq.push_back('{cyc, req_ready});
    end
  end

  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] hd(input int idx, input int b);
    return 32'hA500_0000 | 32'(idx << 8) | 32'(b);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    fq.delete();
    frq.delete();
    gq.delete();
  endtask

  // Presents one request and returns the cycle in which it was accepted.
  task automatic send(input int ch, input int len, input int idx, input int addr,
                      input int hdr, output int gcyc);
    int n;
    @(posedge clk); #1;
    req_valid[ch]          = 1'b1;
    req_len[ch*2 +: 2]     = 2'(len);
    req_idx[ch*4 +: 4]     = 4'(idx);
    req_addr[ch*16 +: 16]  = 16'(addr);
    req_hdr[ch*16 +: 16]   = 16'(hdr);
    #1;
    n = 0;
    while (!req_ready[ch] && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    check($sformatf("grant_ch%0d", ch), 32'(req_ready[ch]), 32'd1);
    gcyc = cyc;
    @(posedge clk); #1;
    req_valid[ch] = 1'b0;
  endtask

  initial begin
    int g;
    int x;
    req_valid = 2'b11;
    for (int i = 0; i < 8; i++) begin
      for (int b = 0; b < 4; b++) begin
        @(posedge clk); #1;
        heap_wen = 1'b1; heap_widx = 4'(i); heap_wclnum = 2'(b); heap_wdata = hd(i, b);
      end
    end
    @(posedge clk); #1;
    heap_wen = 1'b0;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_free_en", 32'(free_en), 32'd0);
    req_valid = 2'b00;
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // single-beat packet
    clear_q();
    send(0, 0, 5, 'h100, 'hAB01, g);
    repeat (8) @(posedge clk); #1;
    check("t1_nflit", 32'(fq.size()), 32'd1);
    if (fq.size() >= 1) begin
      check("t1_cyc", 32'(fq[0].cyc), 32'(g + 4));
      check("t1_addr", 32'(fq[0].addr), 32'h100);
      check("t1_sop", 32'(fq[0].sop), 32'd1);
      check("t1_eop", 32'(fq[0].eop), 32'd1);
      check("t1_data", fq[0].data, hd(5, 0));
      check("t1_hdr", 32'(fq[0].hdr), 32'hAB01);
      check("t1_chan", 32'(fq[0].chan), 32'd0);
    end
    check("t1_nfree", 32'(frq.size()), 32'd1);
    if (frq.size() >= 1) begin
      check("t1_free_cyc", 32'(frq[0].cyc), 32'(g + 2));
      check("t1_free_idx", 32'(frq[0].idx), 32'd5);
    end

    // four-beat packet
    clear_q();
    send(0, 3, 2, 'h200, 'hAB02, g);
    repeat (10) @(posedge clk); #1;
    check("t2_nflit", 32'(fq.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (fq.size() > k) begin
        check($sformatf("t2_cyc%0d", k), 32'(fq[k].cyc), 32'(g + 4 + k));
        check($sformatf("t2_addr%0d", k), 32'(fq[k].addr), 32'(16'h200 + k));
        check($sformatf("t2_sop%0d", k), 32'(fq[k].sop), 32'(k == 0));
        check($sformatf("t2_eop%0d", k), 32'(fq[k].eop), 32'(k == 3));
        check($sformatf("t2_data%0d", k), fq[k].data, hd(2, k));
      end
    end
    check("t2_nfree", 32'(frq.size()), 32'd1);
    if (frq.size() >= 1) begin
      check("t2_free_cyc", 32'(frq[0].cyc), 32'(g + 5));
      check("t2_free_idx", 32'(frq[0].idx), 32'd2);
    end

    // almost-full stall of 10 cycles after the first beat
    clear_q();
    send(0, 3, 3, 'h300, 'hAB03, g);
    @(posedge clk); #1;
    fiu_alm_full = 1'b1;
    repeat (10) @(posedge clk); #1;
    fiu_alm_full = 1'b0;
    repeat (10) @(posedge clk); #1;
    check("t3_nflit", 32'(fq.size()), 32'd4);
    if (fq.size() >= 2) begin
      check("t3_cyc0", 32'(fq[0].cyc), 32'(g + 4));
      check("t3_cyc1", 32'(fq[1].cyc), 32'(g + 15));
    end
    for (int k = 0; k < 4; k++) begin
      if (fq.size() > k) begin
        check($sformatf("t3_addr%0d", k), 32'(fq[k].addr), 32'(16'h300 + k));
        check($sformatf("t3_data%0d", k), fq[k].data, hd(3, k));
      end
    end
    check("t3_nfree", 32'(frq.size()), 32'd1);

    // reset during beat 2 of 4
    clear_q();
    send(0, 3, 4, 'h400, 'hAB04, g);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk); #1;
    reset = 1'b0;
    repeat (8) @(posedge clk); #1;
    check("t5_nflit", 32'(fq.size()), 32'd0);
    check("t5_nfree", 32'(frq.size()), 32'd0);
    check("t5_out_valid", 32'(out_valid), 32'd0);
    check("t5_free_en", 32'(free_en), 32'd0);

    // both channels continuously valid, two-beat packets
    clear_q();
    @(posedge clk); #1;
    req_len = {2'd1, 2'd1};
    req_idx = {4'd7, 4'd6};
    req_addr = {16'h0700, 16'h0600};
    req_hdr = {16'hC111, 16'hC000};
    req_valid = 2'b11;
    x = cyc;
    repeat (5) @(posedge clk); #1;
    req_valid = 2'b00;
    repeat (10) @(posedge clk); #1;
    check("t4_ngrant", 32'(gq.size()), 32'd3);
    for (int k = 0; k < 3; k++) begin
      if (gq.size() > k) begin
        check($sformatf("t4_gcyc%0d", k), 32'(gq[k].cyc), 32'(x + 2 * k));
        check($sformatf("t4_gnt%0d", k), 32'(gq[k].rdy), (k == 1) ? 32'd2 : 32'd1);
      end
    end
    check("t4_nflit", 32'(fq.size()), 32'd6);
    for (int k = 0; k < 6; k++) begin
      if (fq.size() > k) begin
        automatic int ch = (k / 2) % 2;
        check($sformatf("t4_cyc%0d", k), 32'(fq[k].cyc), 32'(x + 4 + k));
        check($sformatf("t4_chan%0d", k), 32'(fq[k].chan), 32'(ch));
        check($sformatf("t4_addr%0d", k), 32'(fq[k].addr), 32'((ch == 0 ? 'h600 : 'h700) + k % 2));
        check($sformatf("t4_sop%0d", k), 32'(fq[k].sop), 32'(k % 2 == 0));
        check($sformatf("t4_eop%0d", k), 32'(fq[k].eop), 32'(k % 2 == 1));
        check($sformatf("t4_data%0d", k), fq[k].data, hd(ch == 0 ? 6 : 7, k % 2));
        check($sformatf("t4_hdr%0d", k), 32'(fq[k].hdr), (ch == 0) ? 32'hC000 : 32'hC111);
      end
    end
    check("t4_nfree", 32'(frq.size()), 32'd3);

`ifdef CCI_MPF_WR_SEQ_STATS_EN
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk); #1;
    reset = 1'b0;
    send(0, 3, 1, 'h100, 'h1, g);
    @(posedge clk); #1;
    fiu_alm_full = 1'b1;
    repeat (5) @(posedge clk); #1;
    fiu_alm_full = 1'b0;
    send(0, 3, 2, 'h200, 'h2, g);
    send(0, 3, 3, 'h300, 'h3, g);
    repeat (10) @(posedge clk); #1;
    check("st_pkts", stat_pkts, 32'd3);
    check("st_beats", stat_beats, 32'd12);
    check("st_stalls", stat_stalls, 32'd5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
